// File: rtl/hlsm_job_driver.sv
// Initiator side of the HLSM Start/Done handshake: gathers one job from a word
// stream, pulses Start, waits for Done (with timeout) and returns the result.
module hlsm_job_driver #(
  parameter int W       = 8,
  parameter int N_OPS   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  output logic [N_OPS*W-1:0] ops,
  output logic [W-1:0]       num,
  output logic               Start,
  input  logic               Done,
  input  logic [W-1:0]       avg,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_data,
  output logic               res_err,
  output logic [1:0]         dbg_state
);

  localparam int CNT_W = $clog2(N_OPS + 1);
  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESULT  = 2'd3
  } state_t;

  // Handshakes: a stream word moves on in_valid && in_ready, a result on
  // res_valid && res_ready; neither side may drop valid before the transfer.
  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [TMO_W-1:0]     tmo_q;
  logic [N_OPS*W-1:0]   ops_q;
  logic [W-1:0]         num_q;
  logic                 start_q;
  logic                 res_valid_q;
  logic [W-1:0]         res_data_q;
  logic                 res_err_q;

  // tmo_q counts cycles since the Start cycle (0 during Start itself).
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= S_COLLECT;
      cnt_q       <= '0;
      tmo_q       <= '0;
      ops_q       <= '0;
      num_q       <= '0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (in_valid) begin
            if (cnt_q == CNT_W'(N_OPS)) begin
              num_q <= in_data;
              cnt_q <= '0;
              if (in_data == '0) begin
                res_valid_q <= 1'b1;
                res_err_q   <= 1'b1;
                res_data_q  <= '0;
                state_q     <= S_RESULT;
              end else begin
                start_q <= 1'b1;
                tmo_q   <= '0;
                state_q <= S_START;
              end
            end else begin
              ops_q[cnt_q*W +: W] <= in_data;
              cnt_q               <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_START: begin
          start_q <= 1'b0;
          tmo_q   <= tmo_q + TMO_W'(1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (Done) begin
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b0;
            res_data_q  <= avg;
            state_q     <= S_RESULT;
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
            res_data_q  <= '0;
            state_q     <= S_RESULT;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_COLLECT;
          end
        end
        default: state_q <= S_COLLECT;
      endcase
    end
  end

  assign in_ready  = (state_q == S_COLLECT);
  assign ops       = ops_q;
  assign num       = num_q;
  assign Start     = start_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hlsm_job_driver.sv
// Bench for hlsm_job_driver: directed scenarios plus randomized jobs, with a
// small HLSM stand-in that answers Done after a chosen delay.
module tb_hlsm_job_driver;

  localparam int W       = 8;
  localparam int N_OPS   = 8;
  localparam int TIMEOUT = 64;

  logic               Clk = 1'b0;
  logic               Rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [W-1:0]       in_data = '0;
  logic [N_OPS*W-1:0] ops;
  logic [W-1:0]       num;
  logic               Start;
  logic               Done = 1'b0;
  logic [W-1:0]       avg = '0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [W-1:0]       res_data;
  logic               res_err;
  logic [1:0]         dbg_state;

  hlsm_job_driver #(.W(W), .N_OPS(N_OPS), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ops(ops), .num(num), .Start(Start), .Done(Done),
    .avg(avg), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] job_w [0:N_OPS];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_words(input int gap_max);
    for (int i = 0; i <= N_OPS; i++) begin
      int g;
      g = $urandom_range(0, gap_max);
      in_valid = 1'b0;
      for (int j = 0; j < g; j++) tick();
      checks++;
      if (in_ready !== 1'b1 || Start !== 1'b0 || res_valid !== 1'b0) begin
        errors++;
        $display("FAIL collect_word%0d: in_ready=%b Start=%b res_valid=%b, want 1/0/0",
                 i, in_ready, Start, res_valid);
      end
      in_valid = 1'b1;
      in_data  = job_w[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic consume(input int hold, input bit spurious);
    logic [W:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if (res_valid !== 1'b1 || {res_err, res_data} !== exp) begin
      errors++;
      $display("FAIL result_value: valid=%b err=%b data=%0d, want 1/%b/%0d",
               res_valid, res_err, res_data, exp[W], exp[W-1:0]);
    end
    for (int j = 0; j < hold; j++) begin
      res_ready = 1'b0;
      if (spurious) begin
        Done = 1'b1;
        avg  = W'($urandom);
      end
      tick();
      Done = 1'b0;
      checks++;
      if (res_valid !== 1'b1 || {res_err, res_data} !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL result_hold: valid=%b err=%b data=%0d in_ready=%b, want 1/%b/%0d/0",
                 res_valid, res_err, res_data, in_ready, exp[W], exp[W-1:0]);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL result_release: res_valid=%b in_ready=%b, want 0/1", res_valid, in_ready);
    end
  endtask

  // d = cycles after the Start cycle at which the stand-in HLSM raises Done.
  task automatic run_job(input int d, input logic [W-1:0] a, input int hold,
                         input int gap_max, input bit spurious);
    logic [N_OPS*W-1:0] exp_ops;
    int   exp_cyc;
    logic exp_err;
    logic [W-1:0] exp_data;
    int   k;
    bit   seen;
    for (int i = 0; i < N_OPS; i++) exp_ops[i*W +: W] = job_w[i];
    if (job_w[N_OPS] == '0) begin
      exp_err = 1'b1; exp_data = '0; exp_cyc = 0;
    end else if (d >= 1 && d <= TIMEOUT - 1) begin
      exp_err = 1'b0; exp_data = a; exp_cyc = d + 1;
    end else begin
      exp_err = 1'b1; exp_data = '0; exp_cyc = TIMEOUT;
    end
    exp_q.push_back({exp_err, exp_data});
    send_words(gap_max);
    checks++;
    if (ops !== exp_ops || num !== job_w[N_OPS]) begin
      errors++;
      $display("FAIL operand_bus: ops=%h num=%0d, want %h/%0d", ops, num, exp_ops, job_w[N_OPS]);
    end
    if (job_w[N_OPS] == '0) begin
      checks++;
      if (Start !== 1'b0 || res_valid !== 1'b1) begin
        errors++;
        $display("FAIL zero_div: Start=%b res_valid=%b, want 0/1", Start, res_valid);
      end
    end else begin
      checks++;
      if (Start !== 1'b1 || res_valid !== 1'b0) begin
        errors++;
        $display("FAIL start_pulse: Start=%b res_valid=%b, want 1/0", Start, res_valid);
      end
      k = 0;
      seen = 1'b0;
      while (!seen && k < TIMEOUT + 4) begin
        Done = (k == d);
        avg  = (k == d) ? a : W'($urandom);
        tick();
        k++;
        Done = 1'b0;
        checks++;
        if (Start !== 1'b0 || in_ready !== 1'b0 || ops !== exp_ops || num !== job_w[N_OPS]) begin
          errors++;
          $display("FAIL wait_hold k=%0d: Start=%b in_ready=%b ops=%h num=%0d, want 0/0/%h/%0d",
                   k, Start, in_ready, ops, num, exp_ops, job_w[N_OPS]);
        end
        if (res_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || k != exp_cyc) begin
        errors++;
        $display("FAIL result_latency: seen=%b after %0d cycles, want %0d", seen, k, exp_cyc);
      end
    end
    consume(hold, spurious);
  endtask

  task automatic load_seq(input logic [W-1:0] div);
    for (int i = 0; i < N_OPS; i++) job_w[i] = W'(i + 1);
    job_w[N_OPS] = div;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || Start !== 1'b0 || res_valid !== 1'b0 || res_err !== 1'b0 ||
        res_data !== '0 || ops !== '0 || num !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b Start=%b rv=%b re=%b rd=%0d ops=%h num=%0d, want 1/0/0/0/0/0/0",
               in_ready, Start, res_valid, res_err, res_data, ops, num);
    end
    Rst = 1'b1;
  endtask

  task automatic test_normal();
    load_seq(W'(4));
    run_job(11, W'(9), 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    load_seq(W'(4));
    run_job(11, W'(9), 5, 2, 1'b0);
  endtask

  task automatic test_zero_div();
    load_seq(W'(0));
    run_job(11, W'(9), 2, 1, 1'b0);
  endtask

  task automatic test_timeout();
    load_seq(W'(3));
    run_job(TIMEOUT + 100, W'(5), 1, 0, 1'b0);
    load_seq(W'(3));
    run_job(TIMEOUT - 1, W'(77), 0, 0, 1'b0);
  endtask

  task automatic test_spurious_done();
    for (int j = 0; j < 3; j++) begin
      Done = 1'b1;
      avg  = W'($urandom);
      tick();
      Done = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1 || Start !== 1'b0) begin
        errors++;
        $display("FAIL spurious_collect: rv=%b in_ready=%b Start=%b, want 0/1/0",
                 res_valid, in_ready, Start);
      end
    end
    load_seq(W'(2));
    run_job(5, W'(33), 4, 1, 1'b1);
    load_seq(W'(6));
    run_job(7, W'(-12), 0, 1, 1'b0);
  endtask

  task automatic test_reset_mid_job();
    load_seq(W'(4));
    send_words(0);
    for (int j = 0; j < 4; j++) tick();
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    checks++;
    if (Start !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b1 || ops !== '0 || num !== '0) begin
      errors++;
      $display("FAIL reset_mid_job: Start=%b rv=%b in_ready=%b ops=%h num=%0d, want 0/0/1/0/0",
               Start, res_valid, in_ready, ops, num);
    end
    Done = 1'b1;
    avg  = W'(9);
    tick();
    Done = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (Start !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL late_done: Start=%b rv=%b in_ready=%b, want 0/0/1", Start, res_valid, in_ready);
      end
    end
    load_seq(W'(8));
    run_job(3, W'(4), 1, 0, 1'b0);
  endtask

  task automatic test_back_to_back_random();
    for (int n = 0; n < 10; n++) begin
      int d;
      for (int i = 0; i <= N_OPS; i++) job_w[i] = W'($urandom);
      if ($urandom_range(0, 4) == 0) job_w[N_OPS] = '0;
      case ($urandom_range(0, 3))
        0:       d = TIMEOUT - 1;
        1:       d = TIMEOUT + 5;
        default: d = $urandom_range(1, 40);
      endcase
      run_job(d, W'($urandom), $urandom_range(0, 3), 2, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_zero_div();
    test_timeout();
    test_spurious_done();
    test_reset_mid_job();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
